// File: rtl/ascon_pack.sv
// Shared ASCON state types and source indices.
// Used by ascon_state_mux_reg and state_sel_xor.
package ascon_pack;

  localparam int ASCON_LANES  = 5;
  localparam int ASCON_LANE_W = 64;

  typedef logic [ASCON_LANES-1:0][ASCON_LANE_W-1:0] type_state;

  typedef enum logic [1:0] {
    SRC_INIT = 2'd0,
    SRC_PERM = 2'd1,
    SRC_ABS  = 2'd2
  } src_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } fill_e;

endpackage

// File: rtl/state_sel_xor.sv
// Combinational source select with range check and optional
// lane absorb (enabled by defining STATE_XOR_EN).
module state_sel_xor
  import ascon_pack::*;
#(
  parameter int NUM_SRC = 3,
  parameter int LANES   = ASCON_LANES,
  parameter int LANE_W  = ASCON_LANE_W,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0][LANES-1:0][LANE_W-1:0] src_i,
  input  logic [SEL_W-1:0]                          sel_i,
  input  logic [LANES-1:0][LANE_W-1:0]              xor_i,
  input  logic [LANES-1:0]                          xor_mask_i,
  output logic [LANES-1:0][LANE_W-1:0]              state_o,
  output logic                                      oob_o
);

  localparam logic [SEL_W:0] NUM_SRC_C = (SEL_W+1)'(NUM_SRC);

  logic [SEL_W-1:0] idx;

  // Out-of-range selects fall back to source 0
  assign oob_o = {1'b0, sel_i} >= NUM_SRC_C;
  assign idx   = oob_o ? '0 : sel_i;

`ifdef STATE_XOR_EN
  always_comb begin
    state_o = src_i[idx];
    for (int l = 0; l < LANES; l++) begin
      if (xor_mask_i[l]) begin
        state_o[l] = src_i[idx][l] ^ xor_i[l];
      end
    end
  end
`else
  logic unused_absorb;
  assign unused_absorb = ^{xor_i, xor_mask_i};

  always_comb begin
    state_o = src_i[idx];
  end
`endif

endmodule

// File: rtl/ascon_state_mux_reg.sv
// Registered NUM_SRC-way ASCON state mux with valid/ready handshake.
// Optional absorb XOR on load when STATE_XOR_EN is defined.
module ascon_state_mux_reg
  import ascon_pack::*;
#(
  parameter int NUM_SRC = 3,
  parameter int LANES   = ASCON_LANES,
  parameter int LANE_W  = ASCON_LANE_W,
  parameter int CNT_W   = 8
) (
  input  logic                                      clock_i,
  input  logic                                      resetb_i,
  input  logic [NUM_SRC-1:0][LANES-1:0][LANE_W-1:0] src_i,
  input  logic [$clog2(NUM_SRC)-1:0]                sel_i,
  input  logic                                      src_valid_i,
  output logic                                      src_ready_o,
  input  logic [LANES-1:0][LANE_W-1:0]              xor_i,
  input  logic [LANES-1:0]                          xor_mask_i,
  output logic [LANES-1:0][LANE_W-1:0]              state_o,
  output logic                                      state_valid_o,
  input  logic                                      state_ready_i,
  output logic [CNT_W-1:0]                          load_cnt_o,
  output logic                                      sel_err_o
);

  localparam int SEL_W = $clog2(NUM_SRC);

  fill_e fill_q, fill_d;

  logic [LANES-1:0][LANE_W-1:0] data_q, data_d, sel_state;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic                         err_q, err_d;
  logic                         sel_oob;
  logic                         accept, drain;

  state_sel_xor #(
    .NUM_SRC (NUM_SRC),
    .LANES   (LANES),
    .LANE_W  (LANE_W),
    .SEL_W   (SEL_W)
  ) u_sel (
    .src_i      (src_i),
    .sel_i      (sel_i),
    .xor_i      (xor_i),
    .xor_mask_i (xor_mask_i),
    .state_o    (sel_state),
    .oob_o      (sel_oob)
  );

  assign state_valid_o = (fill_q == ST_FULL);
  assign src_ready_o   = !state_valid_o || state_ready_i;
  assign accept        = src_valid_i && src_ready_o;
  assign drain         = state_valid_o && state_ready_i;

  always_comb begin
    fill_d = fill_q;
    unique case (fill_q)
      ST_EMPTY: if (accept) fill_d = ST_FULL;
      ST_FULL:  if (drain && !accept) fill_d = ST_EMPTY;
      default:  fill_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (accept) begin
      data_d = sel_state;
      cnt_d  = cnt_q + CNT_W'(1);
      err_d  = err_q | sel_oob;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fill_q <= ST_EMPTY;
      data_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      fill_q <= fill_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign state_o    = data_q;
  assign load_cnt_o = cnt_q;
  assign sel_err_o  = err_q;

endmodule

// File: tb/tb_ascon_state_mux_reg.sv
// Self-checking bench for ascon_state_mux_reg: directed vectors
// plus randomized traffic against a behavioural model.
module tb_ascon_state_mux_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rstb;
  logic [2:0][4:0][63:0] src;
  logic [1:0]            sel;
  logic                  vld;
  logic [4:0][63:0]      xr;
  logic [4:0]            xm;
  logic                  rdy;

  logic             src_rdy, st_vld, err;
  logic [4:0][63:0] st;
  logic [7:0]       cnt;

  logic             src_rdy2, st_vld2, err2;
  logic [4:0][63:0] st2;
  logic [1:0]       cnt2;

  ascon_state_mux_reg dut (
    .clock_i       (clk),
    .resetb_i      (rstb),
    .src_i         (src),
    .sel_i         (sel),
    .src_valid_i   (vld),
    .src_ready_o   (src_rdy),
    .xor_i         (xr),
    .xor_mask_i    (xm),
    .state_o       (st),
    .state_valid_o (st_vld),
    .state_ready_i (rdy),
    .load_cnt_o    (cnt),
    .sel_err_o     (err)
  );

  ascon_state_mux_reg #(.CNT_W(2)) dut2 (
    .clock_i       (clk),
    .resetb_i      (rstb),
    .src_i         (src),
    .sel_i         (sel),
    .src_valid_i   (vld),
    .src_ready_o   (src_rdy2),
    .xor_i         (xr),
    .xor_mask_i    (xm),
    .state_o       (st2),
    .state_valid_o (st_vld2),
    .state_ready_i (rdy),
    .load_cnt_o    (cnt2),
    .sel_err_o     (err2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model
  logic [4:0][63:0] m_st;
  bit               m_vld;
  int               m_cnt;
  bit               m_err;

  task automatic check(input string tag,
                       input logic [319:0] got,
                       input logic [319:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_st  = '0;
    m_vld = 0;
    m_cnt = 0;
    m_err = 0;
  endtask

  task automatic m_edge();
    bit ready;
    int s;
    ready = !m_vld || rdy;
    if (vld && ready) begin
      s = (sel >= 3) ? 0 : int'(sel);
      for (int l = 0; l < 5; l++) begin
        m_st[l] = src[s][l];
`ifdef STATE_XOR_EN
        if (xm[l]) m_st[l] = src[s][l] ^ xr[l];
`endif
      end
      m_vld = 1;
      m_cnt = m_cnt + 1;
      if (sel >= 3) m_err = 1;
    end else if (m_vld && rdy) begin
      m_vld = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".rdy"},  320'(src_rdy), 320'(!m_vld || rdy));
    check({tag, ".st"},   st, m_st);
    check({tag, ".vld"},  320'(st_vld), 320'(m_vld));
    check({tag, ".cnt"},  320'(cnt), 320'(m_cnt % 256));
    check({tag, ".cnt2"}, 320'(cnt2), 320'(m_cnt % 4));
    check({tag, ".err"},  320'(err), 320'(m_err));
  endtask

  // Inputs already driven; run one edge and check afterwards
  task automatic tick(input string tag);
    #1 check({tag, ".rdy0"}, 320'(src_rdy), 320'(!m_vld || rdy));
    @(posedge clk);
    if (rstb) m_edge();
    #1 check_all(tag);
  endtask

  task automatic rand_src();
    for (int s = 0; s < 3; s++)
      for (int l = 0; l < 5; l++)
        src[s][l] = {$urandom, $urandom};
    for (int l = 0; l < 5; l++) xr[l] = {$urandom, $urandom};
    xm = 5'($urandom);
  endtask

  initial begin
    rstb = 1'b0;
    vld  = 1'b0;
    rdy  = 1'b1;
    sel  = 2'd0;
    xm   = '0;
    xr   = '0;
    src  = '0;
    m_reset();

    // Reset and idle
    for (int i = 0; i < 3; i++) tick("rst");
    @(negedge clk) rstb = 1'b1;
    for (int i = 0; i < 3; i++) tick("idle");

    // Reference vectors, select 0 then 1
    @(negedge clk);
    src[0] = {64'hdcdddddfd9dddddd, 64'h8899aabbccddeeff,
              64'h0011223344556677, 64'h08090a0b0c0d0e0f,
              64'h0001020304050607};
    src[0][0] = 64'h80400c0600000000;
    src[0][4] = 64'h8899aabbccddeeff;
    src[0][3] = 64'h0011223344556677;
    src[0][2] = 64'h08090a0b0c0d0e0f;
    src[0][1] = 64'h0001020304050607;
    src[1][0] = 64'he05e3fcced08e4f0;
    src[1][1] = 64'h0dc4f1a5aea83522;
    src[1][2] = 64'hfd3d3d3d3d3d3d57;
    src[1][3] = 64'hdcd8f4c7e363e010;
    src[1][4] = 64'hdcdddddfd9dddddd;
    xm = 5'b00001;
    xr[0] = 64'hffffffffffffffff;
    vld = 1'b1;
    sel = 2'd0;
    tick("sel0");
`ifdef STATE_XOR_EN
    check("absorb.l0", 320'(st[0]), 320'(64'h7fbff3f9ffffffff));
`else
    check("sel0.l0", 320'(st[0]), 320'(64'h80400c0600000000));
`endif
    check("sel0.l4", 320'(st[4]), 320'(64'h8899aabbccddeeff));
    sel = 2'd1;
    tick("sel1");
    check("sel1.cnt", 320'(cnt), 320'd2);

    // Backpressure with valid held high
    rdy = 1'b0;
    sel = 2'd0;
    for (int i = 0; i < 3; i++) tick("bp");
    check("bp.rdy", 320'(src_rdy), 320'd0);
    check("bp.cnt", 320'(cnt), 320'd2);
    rdy = 1'b1;
    tick("bp.rel");
    check("bp.vld", 320'(st_vld), 320'd1);

    // Out-of-range select loads source 0 and sets sticky error
    sel = 2'd3;
    tick("oob");
    vld = 1'b0;
    sel = 2'd1;
    for (int i = 0; i < 2; i++) tick("oob.hold");
    check("oob.err", 320'(err), 320'd1);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rand_src();
      vld = 1'($urandom_range(0, 99) < 70);
      rdy = 1'($urandom_range(0, 99) < 65);
      sel = 2'($urandom_range(0, 3));
      tick("rnd");
    end

    // Reset mid-transfer takes effect at once
    vld = 1'b1;
    rdy = 1'b0;
    tick("pre");
    #2 rstb = 1'b0;
    m_reset();
    #1 check_all("arst");
    @(negedge clk) rstb = 1'b1;
    vld = 1'b0;
    tick("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
